// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter:
// ALU control codes, FSM states and response flag bit positions.
package alu_arbiter_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam int unsigned FLG_ZERO = 0;
  localparam int unsigned FLG_COUT = 1;
  localparam int unsigned FLG_OVF  = 2;
  localparam int unsigned FLG_ERR  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic ctrl_legal(input logic [3:0] c);
    case (c)
      CTRL_AND, CTRL_OR, CTRL_ADD,
      CTRL_SUB, CTRL_SLT, CTRL_NOR: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Per-requester request/response channel of the ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if;

  logic        valid;
  logic        ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ctrl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  modport master (
    output valid, src1, src2, ctrl, rsp_ready,
    input  ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  valid, src1, src2, ctrl, rsp_ready,
    output ready, rsp_valid, rsp_result, rsp_flags
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant; on contention the requester
// that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (valid_i == 2'b11): gnt_o = last_i ? 2'b01 : 2'b10;
      (valid_i == 2'b01): gnt_o = 2'b01;
      (valid_i == 2'b10): gnt_o = 2'b10;
      default:            gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters.
// Define ALU_ARBITER_OPCHECK_EN to reject illegal ALU control codes.
import alu_arbiter_pkg::*;

module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  req0,
  alu_arbiter_if.slave  req1,
  output logic [31:0]   alu_src1,
  output logic [31:0]   alu_src2,
  output logic [3:0]    alu_ctrl,
  input  logic [31:0]   alu_result,
  input  logic          alu_zero,
  input  logic          alu_cout,
  input  logic          alu_overflow
);

  localparam logic [2:0] LAT = 3'(ALU_LAT);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        own_q, own_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  flg_q, flg_d;

  logic [1:0]  gnt;
  logic [31:0] sel_src1;
  logic [31:0] sel_src2;
  logic [3:0]  sel_ctrl;
  logic        issue_ok;
  logic        rsp_rdy;

  rr_arb2 u_arb (
    .valid_i ({req1.valid, req0.valid}),
    .last_i  (last_q),
    .gnt_o   (gnt)
  );

  assign sel_src1 = gnt[1] ? req1.src1 : req0.src1;
  assign sel_src2 = gnt[1] ? req1.src2 : req0.src2;
  assign sel_ctrl = gnt[1] ? req1.ctrl : req0.ctrl;
  assign rsp_rdy  = own_q ? req1.rsp_ready : req0.rsp_ready;

`ifdef ALU_ARBITER_OPCHECK_EN
  assign issue_ok = ctrl_legal(sel_ctrl);
`else
  assign issue_ok = 1'b1;
`endif

  assign req0.ready = rst_n & (state_q == S_IDLE) & gnt[0];
  assign req1.ready = rst_n & (state_q == S_IDLE) & gnt[1];

  assign req0.rsp_valid  = (state_q == S_RESP) & ~own_q;
  assign req1.rsp_valid  = (state_q == S_RESP) & own_q;
  assign req0.rsp_result = res_q;
  assign req1.rsp_result = res_q;
  assign req0.rsp_flags  = flg_q;
  assign req1.rsp_flags  = flg_q;

  assign alu_src1 = src1_q;
  assign alu_src2 = src2_q;
  assign alu_ctrl = ctrl_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt != 2'b00) begin
          own_d  = gnt[1];
          last_d = gnt[1];
          if (issue_ok) begin
            src1_d  = sel_src1;
            src2_d  = sel_src2;
            ctrl_d  = sel_ctrl;
            cnt_d   = LAT;
            state_d = S_EXEC;
          end else begin
            // rejected op: ALU untouched, error response right away
            res_d          = '0;
            flg_d          = '0;
            flg_d[FLG_ERR] = 1'b1;
            state_d        = S_RESP;
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          res_d           = alu_result;
          flg_d           = '0;
          flg_d[FLG_ZERO] = alu_zero;
          flg_d[FLG_COUT] = alu_cout;
          flg_d[FLG_OVF]  = alu_overflow;
          state_d         = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      cnt_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      ctrl_q  <= CTRL_AND;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU.
// Scenario tasks check hand-computed results inline.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_cout, alu_overflow;
  logic [32:0] sum;
  int          n_cmp = 0;
  int          n_bad = 0;

  alu_arbiter_if r0 ();
  alu_arbiter_if r1 ();

  alu_arbiter #(.ALU_LAT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0         (r0),
    .req1         (r1),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow)
  );

  always #5 clk = ~clk;

  // behavioural single-cycle ALU
  always_comb begin
    sum          = '0;
    alu_result   = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      CTRL_AND: alu_result = alu_src1 & alu_src2;
      CTRL_OR:  alu_result = alu_src1 | alu_src2;
      CTRL_NOR: alu_result = ~(alu_src1 | alu_src2);
      CTRL_SLT: alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      CTRL_ADD: begin
        sum          = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (alu_src1[31] == alu_src2[31]) &&
                       (sum[31] != alu_src1[31]);
      end
      CTRL_SUB: begin
        sum          = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (alu_src1[31] != alu_src2[31]) &&
                       (sum[31] != alu_src1[31]);
      end
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    r0.valid = 0; r0.src1 = 0; r0.src2 = 0; r0.ctrl = 0; r0.rsp_ready = 0;
    r1.valid = 0; r1.src1 = 0; r1.src2 = 0; r1.ctrl = 0; r1.rsp_ready = 0;
  endtask

  task automatic drive(input int n, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      r0.valid = 1; r0.ctrl = c; r0.src1 = a; r0.src2 = b;
    end else begin
      r1.valid = 1; r1.ctrl = c; r1.src1 = a; r1.src2 = b;
    end
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0;
    drive(0, CTRL_ADD, 9, 9);
    drive(1, CTRL_OR, 3, 3);
    tick();
    #1;
    n_cmp++;
    if ({r0.ready, r1.ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 00", {r0.ready, r1.ready});
    end
    n_cmp++;
    if ({alu_src1, alu_src2, alu_ctrl} !== 68'd0) begin
      n_bad++;
      $display("FAIL reset_alu: got %h %h %h want 0", alu_src1, alu_src2, alu_ctrl);
    end
    n_cmp++;
    if ({r0.rsp_valid, r1.rsp_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_rspv: got %b want 00", {r0.rsp_valid, r1.rsp_valid});
    end
    n_cmp++;
    if ({r0.rsp_result, r0.rsp_flags, r1.rsp_result, r1.rsp_flags} !== 72'd0) begin
      n_bad++;
      $display("FAIL reset_rsp: got %h %h want 0", r0.rsp_result, r0.rsp_flags);
    end
    idle_inputs();
    tick();
    rst_n = 1;
  endtask

  task automatic test_single;
    drive(0, CTRL_ADD, 5, 7);
    #1;
    n_cmp++;
    if (r0.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_ready: got %b want 1", r0.ready);
    end
    tick();
    r0.valid = 0;
    #1;
    n_cmp++;
    if ({r0.rsp_valid, alu_src1, alu_src2, alu_ctrl} !== {1'b0, 32'd5, 32'd7, CTRL_ADD}) begin
      n_bad++;
      $display("FAIL single_issue: got %b %h %h %h want 0 5 7 2",
               r0.rsp_valid, alu_src1, alu_src2, alu_ctrl);
    end
    tick();
    #1;
    n_cmp++;
    if ({r0.rsp_valid, r1.rsp_valid, r0.rsp_result, r0.rsp_flags} !==
        {1'b1, 1'b0, 32'd12, 4'b0000}) begin
      n_bad++;
      $display("FAIL single_rsp: got %b %b %h %b want 1 0 c 0000",
               r0.rsp_valid, r1.rsp_valid, r0.rsp_result, r0.rsp_flags);
    end
    r0.rsp_ready = 1;
    tick();
    r0.rsp_ready = 0;
    #1;
    n_cmp++;
    if (r0.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_done: got %b want 0", r0.rsp_valid);
    end
  endtask

  task automatic test_rr_first;
    do_reset();
    drive(0, CTRL_SUB, 3, 3);
    drive(1, CTRL_SLT, 32'hFFFF_FFFF, 2);
    #1;
    n_cmp++;
    if ({r0.ready, r1.ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL rr_first_grant: got %b want 10", {r0.ready, r1.ready});
    end
    tick();
    r0.valid = 0;
    tick();
    #1;
    n_cmp++;
    if ({r0.rsp_valid, r0.rsp_result, r0.rsp_flags[FLG_ZERO], r1.ready} !==
        {1'b1, 32'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL rr_sub_rsp: got %b %h z=%b rdy1=%b want 1 0 1 0",
               r0.rsp_valid, r0.rsp_result, r0.rsp_flags[FLG_ZERO], r1.ready);
    end
    r0.rsp_ready = 1;
    tick();
    r0.rsp_ready = 0;
    #1;
    n_cmp++;
    if (r1.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rr_second_grant: got %b want 1", r1.ready);
    end
    tick();
    r1.valid = 0;
    tick();
    #1;
    n_cmp++;
    if ({r1.rsp_valid, r0.rsp_valid, r1.rsp_result} !== {1'b1, 1'b0, 32'd1}) begin
      n_bad++;
      $display("FAIL rr_slt_rsp: got %b %b %h want 1 0 1",
               r1.rsp_valid, r0.rsp_valid, r1.rsp_result);
    end
    r1.rsp_ready = 1;
    tick();
    r1.rsp_ready = 0;
  endtask

  task automatic test_alternate;
    int k;
    logic own;
    do_reset();
    drive(0, CTRL_ADD, 1, 1);
    drive(1, CTRL_ADD, 2, 2);
    for (int op = 0; op < 4; op++) begin
      own = op[0];
      k = 0;
      #1;
      while (!(r0.ready | r1.ready) && k < 10) begin
        tick();
        #1;
        k++;
      end
      n_cmp++;
      if ({r0.ready, r1.ready} !== (own ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL alt_grant op%0d: got %b want %b", op,
                 {r0.ready, r1.ready}, own ? 2'b01 : 2'b10);
      end
      tick();
      k = 0;
      #1;
      while (!(own ? r1.rsp_valid : r0.rsp_valid) && k < 10) begin
        tick();
        #1;
        k++;
      end
      n_cmp++;
      if ((own ? {r1.rsp_valid, r1.rsp_result} : {r0.rsp_valid, r0.rsp_result}) !==
          {1'b1, own ? 32'd4 : 32'd2}) begin
        n_bad++;
        $display("FAIL alt_rsp op%0d: got %b %h want 1 %0d", op,
                 own ? r1.rsp_valid : r0.rsp_valid,
                 own ? r1.rsp_result : r0.rsp_result, own ? 4 : 2);
      end
      if (own) r1.rsp_ready = 1;
      else r0.rsp_ready = 1;
      tick();
      r0.rsp_ready = 0;
      r1.rsp_ready = 0;
    end
    idle_inputs();
  endtask

  task automatic test_backpressure;
    drive(0, CTRL_ADD, 32'h7FFF_FFFF, 1);
    #1;
    n_cmp++;
    if (r0.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_ready: got %b want 1", r0.ready);
    end
    tick();
    r0.valid = 0;
    tick();
    drive(1, CTRL_AND, 32'h0000_F0F0, 32'h0000_FF00);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({r0.rsp_valid, r0.rsp_result, r0.rsp_flags, r1.ready} !==
          {1'b1, 32'h8000_0000, 4'b0100, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold c%0d: got %b %h %b rdy1=%b want 1 80000000 0100 0",
                 i, r0.rsp_valid, r0.rsp_result, r0.rsp_flags, r1.ready);
      end
      tick();
    end
    r0.rsp_ready = 1;
    tick();
    r0.rsp_ready = 0;
    #1;
    n_cmp++;
    if ({r0.rsp_valid, r1.ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_release: got %b want 01", {r0.rsp_valid, r1.ready});
    end
    tick();
    r1.valid = 0;
    tick();
    #1;
    n_cmp++;
    if ({r1.rsp_valid, r1.rsp_result, r1.rsp_flags} !== {1'b1, 32'h0000_F000, 4'b0000}) begin
      n_bad++;
      $display("FAIL bp_and_rsp: got %b %h %b want 1 f000 0000",
               r1.rsp_valid, r1.rsp_result, r1.rsp_flags);
    end
    r1.rsp_ready = 1;
    tick();
    r1.rsp_ready = 0;
  endtask

  task automatic test_reset_exec;
    drive(0, CTRL_OR, 3, 4);
    tick();
    r0.valid = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({r0.rsp_valid, r1.rsp_valid} !== 2'b00) begin
        n_bad++;
        $display("FAIL rexec_norsp c%0d: got %b want 00", i, {r0.rsp_valid, r1.rsp_valid});
      end
      tick();
    end
    n_cmp++;
    if ({alu_src1, alu_ctrl} !== 36'd0) begin
      n_bad++;
      $display("FAIL rexec_alu: got %h %h want 0", alu_src1, alu_ctrl);
    end
    drive(0, CTRL_ADD, 10, 20);
    drive(1, CTRL_ADD, 1, 1);
    #1;
    n_cmp++;
    if ({r0.ready, r1.ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL rexec_grant: got %b want 10", {r0.ready, r1.ready});
    end
    tick();
    idle_inputs();
    tick();
    #1;
    n_cmp++;
    if ({r0.rsp_valid, r0.rsp_result, r0.rsp_flags} !== {1'b1, 32'd30, 4'b0000}) begin
      n_bad++;
      $display("FAIL rexec_rsp: got %b %h %b want 1 1e 0000",
               r0.rsp_valid, r0.rsp_result, r0.rsp_flags);
    end
    r0.rsp_ready = 1;
    tick();
    r0.rsp_ready = 0;
  endtask

  task automatic test_opcheck;
    drive(0, 4'b0101, 1, 2);
    tick();
    r0.valid = 0;
    #1;
`ifdef ALU_ARBITER_OPCHECK_EN
    n_cmp++;
    if ({r0.rsp_valid, alu_ctrl, alu_src1, r0.rsp_result, r0.rsp_flags} !==
        {1'b1, CTRL_ADD, 32'd10, 32'd0, 4'b1000}) begin
      n_bad++;
      $display("FAIL opchk_err: got %b %h %h %h %b want 1 2 a 0 1000",
               r0.rsp_valid, alu_ctrl, alu_src1, r0.rsp_result, r0.rsp_flags);
    end
`else
    n_cmp++;
    if ({r0.rsp_valid, alu_ctrl, alu_src1} !== {1'b0, 4'b0101, 32'd1}) begin
      n_bad++;
      $display("FAIL opchk_issue: got %b %h %h want 0 5 1",
               r0.rsp_valid, alu_ctrl, alu_src1);
    end
    tick();
    #1;
    n_cmp++;
    if ({r0.rsp_valid, r0.rsp_flags[FLG_ERR]} !== 2'b10) begin
      n_bad++;
      $display("FAIL opchk_noerr: got %b %b want 1 0",
               r0.rsp_valid, r0.rsp_flags[FLG_ERR]);
    end
`endif
    r0.rsp_ready = 1;
    tick();
    r0.rsp_ready = 0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_rr_first();
    test_alternate();
    test_backpressure();
    test_reset_exec();
    test_opcheck();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
